// File: rtl/audio_i2s_transmitter.sv
// audio_i2s_transmitter
//   Serialises an unsigned mixer sample onto an I2S (or left-justified) bus.
//   The sample is converted from offset-binary to two's complement and
//   left-justified into a SLOT_WIDTH slot. The same word goes out in both the
//   left and right slots. BCLK is divided down from i_clk.
//
//   Build option: define I2S_LEFT_JUSTIFIED_EN for left-justified framing.
//   In that build LRCLK changes together with the slot MSB. Without it, LRCLK
//   uses Philips I2S timing, where LRCLK leads the MSB by one BCLK.
//
// Ports
//   i_clk         system clock
//   i_rst         synchronous active-high reset
//   i_sample      unsigned sample, captured only at frame start (needs SAMPLE_WIDTH >= 2)
//   i_mute        transmit a zero word, captured together with i_sample
//   o_bclk        bit clock, period 2*BCLK_DIV i_clk cycles
//   o_lrclk       word select (0 = left, 1 = right)
//   o_sdata       serial data, MSB first, updated on BCLK falling events
//   o_sample_stb  one-cycle pulse in the cycle the inputs are captured
module audio_i2s_transmitter #(
  parameter int SAMPLE_WIDTH = 9,
  parameter int SLOT_WIDTH   = 16,
  parameter int BCLK_DIV     = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [SAMPLE_WIDTH-1:0] i_sample,
  input  logic                    i_mute,
  output logic                    o_bclk,
  output logic                    o_lrclk,
  output logic                    o_sdata,
  output logic                    o_sample_stb
);

  localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int BW = $clog2(2 * SLOT_WIDTH);

  localparam logic [DW-1:0] DIV_LAST  = DW'(BCLK_DIV - 1);
  localparam logic [BW-1:0] B_LAST    = BW'(2 * SLOT_WIDTH - 1);
  localparam logic [BW-1:0] B_HALF    = BW'(SLOT_WIDTH);
  localparam logic [BW-1:0] B_HALF_M1 = BW'(SLOT_WIDTH - 1);

`ifdef I2S_LEFT_JUSTIFIED_EN
  localparam logic LR_RESET = 1'b1;
`else
  localparam logic LR_RESET = 1'b0;
`endif

  logic [DW-1:0]           div_cnt;
  logic [BW-1:0]           bit_idx;
  logic [BW-1:0]           bit_next;
  logic [SLOT_WIDTH-1:0]   rot;
  logic [SLOT_WIDTH-1:0]   word_new;
  logic [SAMPLE_WIDTH-1:0] conv;
  logic                    tc;
  logic                    fall;
  logic                    lr_next;

  always_comb begin
    tc       = (div_cnt == DIV_LAST);
    fall     = tc & o_bclk;
    bit_next = (bit_idx == B_LAST) ? '0 : bit_idx + 1'b1;
    // Flipping the MSB turns offset-binary into two's complement.
    conv     = {~i_sample[SAMPLE_WIDTH-1], i_sample[SAMPLE_WIDTH-2:0]};
    word_new = i_mute ? '0 : (SLOT_WIDTH'(conv) << (SLOT_WIDTH - SAMPLE_WIDTH));
`ifdef I2S_LEFT_JUSTIFIED_EN
    lr_next  = (bit_next >= B_HALF);
`else
    // Equivalent to ((b+1) mod 2*SLOT_WIDTH) >= SLOT_WIDTH.
    lr_next  = (bit_next >= B_HALF_M1) && (bit_next != B_LAST);
`endif
  end

  // The word is kept in a rotating register. After SLOT_WIDTH shifts it is
  // back in its original position, so the right slot repeats the left slot
  // without a separate copy of the word.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      div_cnt      <= '0;
      bit_idx      <= B_LAST;
      o_bclk       <= 1'b0;
      o_sdata      <= 1'b0;
      o_lrclk      <= LR_RESET;
      o_sample_stb <= 1'b0;
      rot          <= '0;
    end else begin
      o_sample_stb <= 1'b0;
      div_cnt      <= tc ? '0 : div_cnt + 1'b1;
      if (tc) o_bclk <= ~o_bclk;
      if (fall) begin
        bit_idx <= bit_next;
        o_lrclk <= lr_next;
        if (bit_next == '0) begin
          o_sample_stb <= 1'b1;
          o_sdata      <= word_new[SLOT_WIDTH-1];
          rot          <= {word_new[SLOT_WIDTH-2:0], word_new[SLOT_WIDTH-1]};
        end else begin
          o_sdata      <= rot[SLOT_WIDTH-1];
          rot          <= {rot[SLOT_WIDTH-2:0], rot[SLOT_WIDTH-1]};
        end
      end
    end
  end

endmodule

// File: tb/tb_audio_i2s_transmitter.sv
// Bench for audio_i2s_transmitter.
// Instance dut uses the default parameters.
// Instance dut2 uses BCLK_DIV=1 and SLOT_WIDTH=24.
module tb_audio_i2s_transmitter;

  localparam int SW = 9;
  localparam int S  = 16;
  localparam int D  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [SW-1:0] sample = 9'h100;
  logic          mute = 1'b0;
  logic          bclk, lrclk, sdata, stb;

  logic [SW-1:0] sample2 = 9'h000;
  logic          mute2 = 1'b0;
  logic          bclk2, lrclk2, sdata2, stb2;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  audio_i2s_transmitter #(.SAMPLE_WIDTH(SW), .SLOT_WIDTH(S), .BCLK_DIV(D)) dut (
    .i_clk(clk), .i_rst(rst), .i_sample(sample), .i_mute(mute),
    .o_bclk(bclk), .o_lrclk(lrclk), .o_sdata(sdata), .o_sample_stb(stb));

  audio_i2s_transmitter #(.SAMPLE_WIDTH(SW), .SLOT_WIDTH(24), .BCLK_DIV(1)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_sample(sample2), .i_mute(mute2),
    .o_bclk(bclk2), .o_lrclk(lrclk2), .o_sdata(sdata2), .o_sample_stb(stb2));

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model. It works from elapsed time since reset release:
  // t clocks after release, BCLK has completed t/(2D) falling events, and
  // frame k's word was captured at t = 2D + k*4SD.
  int       t = 0;
  longint   w_m = 0;
  always @(posedge clk) begin
    int f, b;
    logic e_bclk, e_lr, e_sd, e_stb;
    if (rst) begin
      t = 0;
      w_m = 0;
      e_bclk = 1'b0; e_sd = 1'b0; e_stb = 1'b0;
`ifdef I2S_LEFT_JUSTIFIED_EN
      e_lr = 1'b1;
`else
      e_lr = 1'b0;
`endif
    end else begin
      t++;
      e_stb = (t >= 2*D) && (((t - 2*D) % (4*S*D)) == 0);
      if (e_stb)
        w_m = mute ? 0 : (((int'(sample) - (1 << (SW-1))) * (1 << (S-SW))) & 32'hFFFF);
      f = t / (2*D);
      b = (f + 2*S - 1) % (2*S);
      e_bclk = ((t / D) % 2) == 1;
      e_sd = ((w_m >> (S - 1 - (b % S))) & 1) != 0;
`ifdef I2S_LEFT_JUSTIFIED_EN
      e_lr = (b >= S);
`else
      e_lr = (((b + 1) % (2*S)) >= S);
`endif
    end
    #1;
    check("bclk",  bclk,  e_bclk);
    check("lrclk", lrclk, e_lr);
    check("sdata", sdata, e_sd);
    check("stb",   stb,   e_stb);
  end

  // Checks for dut2 with BCLK_DIV=1 and SLOT_WIDTH=24. Sample 0 must give
  // 24'h800000 in both slots, and a frame must last 96 clocks.
  int          cyc2 = 0;
  bit          have2 = 0;
  int          nbit2 = -1;
  logic [47:0] sh2 = '0;
  logic        pbclk2 = 1'b0;
  always @(posedge clk) begin
    #1;
    if (rst) begin
      have2 = 0; nbit2 = -1; cyc2 = 0; pbclk2 = 1'b0;
    end else begin
      cyc2++;
      check("div1_bclk_toggle", bclk2, !pbclk2);
      pbclk2 = bclk2;
      if (stb2) begin
        if (have2) check("div1_frame_len", cyc2, 96);
        have2 = 1; cyc2 = 0; nbit2 = 0;
      end
      if (nbit2 >= 0 && cyc2 == nbit2 * 2) begin
        sh2 = {sh2[46:0], sdata2};
        nbit2++;
        if (nbit2 == 48) begin
          check("div1_frame_data", sh2, 48'h800000_800000);
          nbit2 = -1;
        end
      end
    end
  end

  task automatic wait_stb(output int n);
    n = 0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1; n++;
      if (stb) return;
    end
    check("stb_timeout", 0, 1);
    n = -1;
  endtask

  // Called at the stb cycle. Collects the left slot as it is shifted out.
  task automatic collect_slot(output logic [S-1:0] v);
    v[S-1] = sdata;
    for (int k = 1; k < S; k++) begin
      repeat (2*D) @(posedge clk);
      #1;
      v[S-1-k] = sdata;
    end
  endtask

  task automatic read_slot(input string name, input logic [S-1:0] exp);
    int n;
    logic [S-1:0] v;
    wait_stb(n);
    if (n >= 0) begin
      collect_slot(v);
      check(name, v, exp);
    end
    @(negedge clk);
  endtask

  initial begin
    int n, cnt;
    logic [S-1:0] v;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // First rising BCLK edge, then first capture strobe.
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1; cnt++;
      if (bclk) break;
    end
    check("first_rise_clk", cnt, 8);
    for (int i = 0; i < 100; i++) begin
      if (stb) break;
      @(posedge clk); #1; cnt++;
    end
    check("first_stb_clk", cnt, 16);

    wait_stb(n);
    check("stb_period", n, 4*S*D);
    @(negedge clk);
    read_slot("midscale", 16'h0000);

    sample = 9'h000;
    read_slot("min_sample", 16'h8000);
    sample = 9'h1FF;
    read_slot("max_sample", 16'h7F80);
    mute = 1'b1;
    read_slot("muted", 16'h0000);
    mute = 1'b0;
    read_slot("unmuted", 16'h7F80);
    // A mute pulse between captures must not touch the frame in flight.
    repeat (40) @(negedge clk);
    mute = 1'b1;
    repeat (5) @(negedge clk);
    mute = 1'b0;
    read_slot("mute_pulse_ignored", 16'h7F80);

    // Random samples and mute, including changes in the middle of a frame.
    for (int fr = 0; fr < 20; fr++) begin
      sample = SW'($urandom);
      mute = ($urandom_range(0, 3) == 0);
      for (int c = 0; c < 4*S*D; c++) begin
        @(negedge clk);
        if ($urandom_range(0, 49) == 0) begin
          sample = SW'($urandom);
          mute = ($urandom_range(0, 3) == 0);
        end
      end
    end
    mute = 1'b0;

    // One-cycle reset in the middle of the right slot.
    wait_stb(n);
    repeat (2*D*(S+4)) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    sample = 9'h0AB;
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1; cnt++;
      if (stb) break;
    end
    check("stb_after_reset_clk", cnt, 16);
    collect_slot(v);
    check("fresh_sample_after_reset", v, 16'hD580);

    repeat (1000) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
